// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: FSM state encoding and default gate/counter sizing for freq_meter
package freq_meter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GATE = 2'd1, DONE = 2'd2} state_t;
  localparam int GATE_CYCLES_DEF = 12000;
  localparam int CNT_WIDTH_DEF = 16;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-flop synchronizer + registered rising-edge pulse (clk, rst_n async active-high, sig_in -> edge_pulse, 3 clk latency)
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic edge_pulse
);
  logic s1, s2, s3;
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) {s1, s2, s3, edge_pulse} <= '0;
    else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
      edge_pulse <= s2 & ~s3;
    end
endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts sig_in rising edges over GATE_CYCLES clk (clk, rst_n async active-high, sig_in, start -> busy, freq_valid, freq_cnt, overflow); FREQ_METER_AUTO_EN makes windows run back-to-back
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sig_in,
  input  logic                 start,
  output logic                 busy,
  output logic                 freq_valid,
  output logic [CNT_WIDTH-1:0] freq_cnt,
  output logic                 overflow
);
  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  state_t state_q, state_d;
  logic [GW-1:0] gate_cnt;
  logic [CNT_WIDTH-1:0] edge_cnt;
  logic ovf_sticky, edge_pulse, gate_end, win_start;
  sync_edge_det u_sync (
    .clk(clk),
    .rst_n(rst_n),
    .sig_in(sig_in),
    .edge_pulse(edge_pulse)
  );
  assign gate_end = gate_cnt == GATE_LAST;
  always_comb begin
    state_d = IDLE;
`ifdef FREQ_METER_AUTO_EN
    state_d = state_q == IDLE ? (start ? GATE : IDLE) : state_q == GATE ? (gate_end ? DONE : GATE) : GATE;
`else
    state_d = state_q == IDLE ? (start ? GATE : IDLE) : state_q == GATE ? (gate_end ? DONE : GATE) : IDLE;
`endif
  end
  assign win_start = state_d == GATE && state_q != GATE;
  assign busy = state_q == GATE;
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      state_q <= IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf_sticky <= 1'b0;
      freq_cnt <= '0;
      overflow <= 1'b0;
      freq_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      freq_valid <= state_q == DONE;
      if (win_start) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        ovf_sticky <= 1'b0;
      end else if (state_q == GATE) begin
        gate_cnt <= gate_cnt + 1'b1;
        if (edge_pulse) begin
          if (edge_cnt == CNT_MAX) ovf_sticky <= 1'b1;
          else edge_cnt <= edge_cnt + 1'b1;
        end
      end
      if (state_q == DONE) begin
        freq_cnt <= edge_cnt;
        overflow <= ovf_sticky;
      end
    end
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: scoreboard bench for freq_meter (16-bit and 3-bit counter instances, 100-cycle gate)
module tb_freq_meter;
  localparam int G = 100;
  logic clk = 1'b0, rst_n = 1'b1, sig_in = 1'b0, start = 1'b0, sig_lvl = 1'b0;
  logic busy0, valid0, ovf0, busy1, valid1, ovf1;
  logic [15:0] cnt0;
  logic [2:0] cnt1;
  int total = 0, bad = 0, cyc = 0, sig_per = 0, ph = 0;
  typedef struct {logic [15:0] cnt; logic ovf; int cyc;} res_t;
  res_t exp_q[$], obs_q[$];
  freq_meter #(.GATE_CYCLES(G)) u0 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start),
    .busy(busy0), .freq_valid(valid0), .freq_cnt(cnt0), .overflow(ovf0)
  );
  freq_meter #(.GATE_CYCLES(G), .CNT_WIDTH(3)) u1 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start),
    .busy(busy1), .freq_valid(valid1), .freq_cnt(cnt1), .overflow(ovf1)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (sig_per == 0) sig_in = sig_lvl;
    else begin
      ph = (ph + 1 >= sig_per) ? 0 : ph + 1;
      sig_in = ph < sig_per / 2;
    end
    if (valid0) obs_q.push_back('{cnt0, ovf0, cyc});
  end
  task automatic start_pulse(output int s);
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_obs(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      #1;
      got = obs_q.size() != 0;
    end
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy0); end
    total++; if (valid0 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid0); end
    total++; if (cnt0 !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt0); end
    total++; if (ovf0 !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf0); end
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL idle_no_start_busy got=%b exp=0", busy0); end
  endtask
  task automatic test_basic;
    int s;
    bit got;
    res_t o, e;
    sig_per = 5;
    repeat (10) @(negedge clk);
    start_pulse(s);
    exp_q.push_back('{16'd20, 1'b0, s + G + 2});
    repeat (50) @(negedge clk);
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy0); end
    wait_obs(G + 20, got);
    total++;
    if (!got) begin bad++; $display("FAIL basic_timeout got=none exp=result"); end
    else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++; if (o.cnt !== e.cnt) begin bad++; $display("FAIL basic_cnt got=%0d exp=%0d", o.cnt, e.cnt); end
      total++; if (o.ovf !== e.ovf) begin bad++; $display("FAIL basic_ovf got=%b exp=%b", o.ovf, e.ovf); end
      total++; if (o.cyc !== e.cyc) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", o.cyc, e.cyc); end
    end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b exp=0", busy0); end
  endtask
  task automatic test_saturate;
    int s;
    bit got;
    res_t o, e;
    sig_per = 2;
    repeat (10) @(negedge clk);
    start_pulse(s);
    exp_q.push_back('{16'd50, 1'b0, s + G + 2});
    wait_obs(G + 20, got);
    total++;
    if (!got) begin bad++; $display("FAIL sat_timeout got=none exp=result"); end
    else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++; if (o.cnt !== e.cnt) begin bad++; $display("FAIL sat_wide_cnt got=%0d exp=%0d", o.cnt, e.cnt); end
      total++; if (o.ovf !== e.ovf) begin bad++; $display("FAIL sat_wide_ovf got=%b exp=%b", o.ovf, e.ovf); end
    end
    total++; if (cnt1 !== 3'd7) begin bad++; $display("FAIL sat_cnt got=%0d exp=7", cnt1); end
    total++; if (ovf1 !== 1'b1) begin bad++; $display("FAIL sat_ovf got=%b exp=1", ovf1); end
    sig_per = 3;
    repeat (30) @(negedge clk);
    total++; if (cnt0 !== 16'd50) begin bad++; $display("FAIL hold_cnt got=%0d exp=50", cnt0); end
    total++; if (cnt1 !== 3'd7 || ovf1 !== 1'b1) begin bad++; $display("FAIL hold_sat got=%0d/%b exp=7/1", cnt1, ovf1); end
  endtask
  task automatic test_hold;
    int s;
    bit got;
    res_t o, e;
    for (int lvl = 0; lvl < 2; lvl++) begin
      sig_per = 0;
      sig_lvl = lvl[0];
      repeat (10) @(negedge clk);
      start_pulse(s);
      exp_q.push_back('{16'd0, 1'b0, s + G + 2});
      wait_obs(G + 20, got);
      total++;
      if (!got) begin bad++; $display("FAIL hold%0d_timeout got=none exp=result", lvl); end
      else begin
        o = obs_q.pop_front(); e = exp_q.pop_front();
        total++; if (o.cnt !== e.cnt) begin bad++; $display("FAIL hold%0d_cnt got=%0d exp=%0d", lvl, o.cnt, e.cnt); end
        total++; if (o.ovf !== e.ovf) begin bad++; $display("FAIL hold%0d_ovf got=%b exp=%b", lvl, o.ovf, e.ovf); end
      end
      total++; if (cnt1 !== 3'd0 || ovf1 !== 1'b0) begin bad++; $display("FAIL hold%0d_narrow got=%0d/%b exp=0/0", lvl, cnt1, ovf1); end
    end
  endtask
  task automatic test_back_to_back;
    int s, s2;
    bit got;
    res_t o, e;
    sig_per = 5;
    repeat (10) @(negedge clk);
    start_pulse(s);
    exp_q.push_back('{16'd20, 1'b0, s + G + 2});
    repeat (29) @(negedge clk);
    start_pulse(s2);
    wait_obs(G + 20, got);
    total++;
    if (!got) begin bad++; $display("FAIL b2b_timeout got=none exp=result"); end
    else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++; if (o.cnt !== e.cnt) begin bad++; $display("FAIL b2b_cnt got=%0d exp=%0d", o.cnt, e.cnt); end
      total++; if (o.cyc !== e.cyc) begin bad++; $display("FAIL b2b_latency got=%0d exp=%0d", o.cyc, e.cyc); end
    end
    repeat (2 * G) @(negedge clk);
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL b2b_extra_valid got=%0d exp=0", obs_q.size()); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%b exp=0", busy0); end
  endtask
  task automatic test_reset_abort;
    int s;
    bit got;
    res_t o, e;
    sig_per = 5;
    start_pulse(s);
    repeat (49) @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy0); end
    total++; if (cnt0 !== 16'd0) begin bad++; $display("FAIL abort_cnt got=%0d exp=0", cnt0); end
    total++; if (ovf0 !== 1'b0) begin bad++; $display("FAIL abort_ovf got=%b exp=0", ovf0); end
    @(negedge clk);
    rst_n = 1'b0;
    repeat (G + 20) @(negedge clk);
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL abort_valid got=%0d exp=0", obs_q.size()); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL abort_restart got=%b exp=0", busy0); end
    start_pulse(s);
    exp_q.push_back('{16'd20, 1'b0, s + G + 2});
    wait_obs(G + 20, got);
    total++;
    if (!got) begin bad++; $display("FAIL abort_rerun_timeout got=none exp=result"); end
    else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++; if (o.cnt !== e.cnt) begin bad++; $display("FAIL abort_rerun_cnt got=%0d exp=%0d", o.cnt, e.cnt); end
      total++; if (o.cyc !== e.cyc) begin bad++; $display("FAIL abort_rerun_latency got=%0d exp=%0d", o.cyc, e.cyc); end
    end
  endtask
  task automatic test_auto;
    int s, prev;
    bit got;
    res_t o;
    sig_per = 4;
    repeat (10) @(negedge clk);
    start_pulse(s);
    prev = s + 1;
    for (int k = 0; k < 3; k++) begin
      wait_obs(G + 20, got);
      total++;
      if (!got) begin bad++; $display("FAIL auto%0d_timeout got=none exp=result", k); end
      else begin
        o = obs_q.pop_front();
        total++; if (o.cnt !== 16'd25 || o.ovf !== 1'b0) begin bad++; $display("FAIL auto%0d_cnt got=%0d/%b exp=25/0", k, o.cnt, o.ovf); end
        total++; if (o.cyc - prev !== G + 1) begin bad++; $display("FAIL auto%0d_period got=%0d exp=%0d", k, o.cyc - prev, G + 1); end
        prev = o.cyc;
      end
    end
  endtask
  initial begin
    test_reset;
`ifdef FREQ_METER_AUTO_EN
    test_auto;
`else
    test_basic;
    test_saturate;
    test_hold;
    test_back_to_back;
    test_reset_abort;
    repeat (5) @(negedge clk);
    total++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d/%0d exp=0/0", exp_q.size(), obs_q.size());
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
